mem_wait_bridge: RTL and testbench
==================================

Name: mem_wait_bridge

Overview:
- Sits directly downstream of the picorv32 native memory interface, between the core and a synchronous single-port word SRAM.
- Converts each mem_valid request into one SRAM access and inserts a programmable number of wait states before mem_ready.
- Decodes two MMIO words: console byte output and test-done/exit code. Simulation benches use these to run firmware to completion under realistic memory latency.

Parameters:
- MEM_WORDS, 4096, SRAM depth in 32-bit words; power of two; AW = $clog2(MEM_WORDS).
- WAIT_CYCLES, 0, extra stall cycles per transaction; range 0..15.
- CONSOLE_ADDR, 32'h1000_0000, MMIO console register byte address.
- DONE_ADDR, 32'h2000_0000, MMIO test-done register byte address.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- mem_valid  in  1  core request valid
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- sram_en  out  1  SRAM access strobe
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  AW  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid one cycle after sram_en
- con_valid  out  1  console byte strobe
- con_data  out  8  console byte
- done  out  1  sticky test-finished flag
- done_code  out  32  value written to DONE_ADDR
- bad_access  out  1  sticky out-of-map access flag
- stat_ifetch, stat_load, stat_store  out  32 each  transaction counters

Behaviour:
- All outputs are registered. On rst: state=IDLE, and every output is 0, including done, done_code, bad_access and the counters.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if mem_valid=1 at a clock edge, latch addr, wdata, wstrb and instr, and go to ACCESS.
- ACCESS (1 cycle) depends on the decoded region:
  - RAM region (addr < MEM_WORDS*4): sram_en=1, sram_we=latched wstrb, sram_addr=addr[AW+1:2].
  - CONSOLE_ADDR with wstrb[0]=1: con_valid=1, con_data=wdata[7:0].
  - DONE_ADDR with any wstrb nonzero: done<=1, done_code<=wdata.
  - Any other address: bad_access<=1; write is dropped.
  - Next state is WAIT.
- WAIT: lasts WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter. The first WAIT cycle captures sram_rdata for RAM reads; every other case uses 0. Next state is RESP.
- RESP: mem_ready=1 with mem_rdata for exactly 1 cycle, then go to IDLE. mem_rdata returns to 0 afterwards.
- Latency: request sampled at edge k; mem_ready is high during the cycle after edge k+2+WAIT_CYCLES. Minimum is 3 cycles from request to sampled ready.
- mem_valid is not re-sampled until back in IDLE. A mem_valid deassertion mid-transaction is ignored and the transaction completes. Back-to-back requests incur no extra idle cycle beyond the RESP→IDLE cycle.
- sram_en and con_valid are single-cycle pulses. sram_we is 0 whenever sram_en=0.
- done stays high after the first DONE write. Later DONE writes update done_code.
- Asynchronous rst mid-transaction: immediate return to IDLE, and no mem_ready is issued.

Optional Feature:
- Macro: MEM_WAIT_BRIDGE_STATS_EN.
- When defined: in RESP, increment exactly one counter.
  - stat_ifetch if instr=1.
  - else stat_load if wstrb=0.
  - else stat_store.
  - Counters wrap modulo 2^32.
- When undefined: counters are not instantiated and the stat outputs are tied to 0.

Decomposition:
- Shared package mem_bridge_pkg holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP);
  - default address constants CONSOLE_ADDR and DONE_ADDR;
  - a region-decode enum (REG_RAM, REG_CON, REG_DONE, REG_BAD).
- One natural sub-module: mem_bridge_decode, combinational address→region.
- FSM, wait counter and counters stay in the top module.

Test Plan:
- WAIT_CYCLES=0; read addr 0x10 with SRAM word 4 = 0xDEADBEEF → sram_en at cycle k+1 with sram_addr=4; mem_ready at cycle k+3 with mem_rdata=0xDEADBEEF.
- WAIT_CYCLES=5; write 0x12345678, wstrb=4'b0011, to 0x20 → sram_we=0011, sram_addr=8; mem_ready at cycle k+8; mem_rdata=0.
- Store byte 0x41 to CONSOLE_ADDR → con_valid pulses once with con_data=0x41; no sram_en.
- Store 0x0000_0001 to DONE_ADDR, then 0x2A → done=1 after the first write, done_code=0x2A after the second.
- Read 0x0800_0000 (unmapped) → mem_rdata=0, bad_access=1 sticky, no sram_en; assert rst while in WAIT → no mem_ready, all outputs 0.
- With MEM_WAIT_BRIDGE_STATS_EN: 3 fetches, 2 loads, 1 store → stat_ifetch=3, stat_load=2, stat_store=1; without the macro all three read 0.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge_pkg
// Description : Shared types and default constants for the memory wait-state
//               bridge (FSM states, address-region codes, MMIO addresses).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } bridge_state_e;

  // Decoded target of a request address
  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_CON  = 2'd1,
    REG_DONE = 2'd2,
    REG_BAD  = 2'd3
  } region_e;

  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DONE_ADDR    = 32'h2000_0000;

  // Word-granular address match; the byte-lane bits never select a register
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bridge_decode.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge_decode
// Description : Combinational byte-address to region decode (RAM, console,
//               test-done, unmapped). RAM takes priority on overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge_decode
  import mem_bridge_pkg::*;
#(
  parameter int          MEM_WORDS    = 4096,
  parameter logic [31:0] CONSOLE_ADDR = mem_bridge_pkg::CONSOLE_ADDR,
  parameter logic [31:0] DONE_ADDR    = mem_bridge_pkg::DONE_ADDR
) (
  input  logic [31:0] addr_i,
  output region_e     region_o
);

  // One bit wider than the address so a 4 GiB map does not wrap to zero
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

  // Classify the address; anything not claimed falls through to unmapped
  always_comb begin
    region_o = REG_BAD;
    if ({1'b0, addr_i} < RAM_BYTES)
      region_o = REG_RAM;
    else if (same_word(addr_i, CONSOLE_ADDR))
      region_o = REG_CON;
    else if (same_word(addr_i, DONE_ADDR))
      region_o = REG_DONE;
  end

endmodule
`default_nettype wire

// File: rtl/mem_wait_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_bridge
// Description : picorv32 native-bus to synchronous word-SRAM bridge with a
//               programmable number of wait states, plus console and
//               test-done MMIO words. Optional transaction counters are
//               built when MEM_WAIT_BRIDGE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          MEM_WORDS    = 4096,
  parameter int          WAIT_CYCLES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = mem_bridge_pkg::CONSOLE_ADDR,
  parameter logic [31:0] DONE_ADDR    = mem_bridge_pkg::DONE_ADDR,
  localparam int         AW           = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic          mem_instr,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic          mem_ready,
  output logic [31:0]   mem_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          con_valid,
  output logic [7:0]    con_data,
  output logic          done,
  output logic [31:0]   done_code,
  output logic          bad_access,
  output logic [31:0]   stat_ifetch,
  output logic [31:0]   stat_load,
  output logic [31:0]   stat_store
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  bridge_state_e state_q, state_d;
  region_e       w_region, region_q;
  logic          w_start;
  logic [31:0]   w_capture;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [3:0]    cnt_q;
  logic          first_q;
  logic [31:0]   data_q;

  logic          mem_ready_q,  mem_ready_d;
  logic [31:0]   mem_rdata_q,  mem_rdata_d;
  logic          sram_en_q,    sram_en_d;
  logic [3:0]    sram_we_q,    sram_we_d;
  logic [AW-1:0] sram_addr_q,  sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;
  logic          con_valid_q,  con_valid_d;
  logic [7:0]    con_data_q,   con_data_d;
  logic          done_q,       done_d;
  logic [31:0]   done_code_q,  done_code_d;
  logic          bad_q,        bad_d;

  mem_bridge_decode #(
    .MEM_WORDS   (MEM_WORDS),
    .CONSOLE_ADDR(CONSOLE_ADDR),
    .DONE_ADDR   (DONE_ADDR)
  ) u_decode (
    .addr_i  (mem_addr),
    .region_o(w_region)
  );

  // A request is only ever accepted from IDLE
  assign w_start = (state_q == IDLE) && mem_valid;

  // State register; async reset aborts any transaction without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed ACCESS slot, then WAIT until the down-counter drains
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_valid) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; ACCESS-cycle strobes are computed at acceptance so
  // they can leave a register while the FSM sits in ACCESS
  always_comb begin
    w_capture    = ((region_q == REG_RAM) && (wstrb_q == 4'd0)) ? sram_rdata : 32'd0;
    sram_en_d    = w_start && (w_region == REG_RAM);
    sram_we_d    = sram_en_d ? mem_wstrb : 4'd0;
    sram_addr_d  = sram_en_d ? mem_addr[AW+1:2] : '0;
    sram_wdata_d = sram_en_d ? mem_wdata : 32'd0;
    con_valid_d  = w_start && (w_region == REG_CON) && mem_wstrb[0];
    con_data_d   = con_valid_d ? mem_wdata[7:0] : 8'd0;
    mem_ready_d  = (state_d == RESP);
    // With zero wait states the capture and the response share one edge
    mem_rdata_d  = mem_ready_d ? (first_q ? w_capture : data_q) : 32'd0;
    done_d       = done_q;
    done_code_d  = done_code_q;
    bad_d        = bad_q;
    if (state_q == ACCESS) begin
      if ((region_q == REG_DONE) && (wstrb_q != 4'd0)) begin
        done_d      = 1'b1;
        done_code_d = wdata_q;
      end
      if (region_q == REG_BAD) bad_d = 1'b1;
    end
  end

  // Registered outputs, latched request context and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready_q  <= 1'b0;
      mem_rdata_q  <= 32'd0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 4'd0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'd0;
      con_valid_q  <= 1'b0;
      con_data_q   <= 8'd0;
      done_q       <= 1'b0;
      done_code_q  <= 32'd0;
      bad_q        <= 1'b0;
      region_q     <= REG_RAM;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      cnt_q        <= 4'd0;
      first_q      <= 1'b0;
      data_q       <= 32'd0;
    end else begin
      mem_ready_q  <= mem_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      con_valid_q  <= con_valid_d;
      con_data_q   <= con_data_d;
      done_q       <= done_d;
      done_code_q  <= done_code_d;
      bad_q        <= bad_d;
      if (w_start) begin
        region_q <= w_region;
        wdata_q  <= mem_wdata;
        wstrb_q  <= mem_wstrb;
      end
      first_q <= (state_q == ACCESS);
      if (state_q == ACCESS)
        cnt_q <= WAIT_INIT;
      else if ((state_q == WAIT) && (cnt_q != 4'd0))
        cnt_q <= cnt_q - 4'd1;
      // SRAM data is valid only in the first WAIT cycle
      if ((state_q == WAIT) && first_q)
        data_q <= w_capture;
    end
  end

  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign con_valid  = con_valid_q;
  assign con_data   = con_data_q;
  assign done       = done_q;
  assign done_code  = done_code_q;
  assign bad_access = bad_q;

`ifdef MEM_WAIT_BRIDGE_STATS_EN
  logic        instr_q;
  logic [31:0] st_if_q, st_ld_q, st_st_q;

  // Remember the fetch flag alongside the rest of the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instr_q <= 1'b0;
    else if (w_start) instr_q <= mem_instr;
  end

  // Classify each completed transaction exactly once, in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_if_q <= 32'd0;
      st_ld_q <= 32'd0;
      st_st_q <= 32'd0;
    end else if (state_q == RESP) begin
      if (instr_q)                st_if_q <= st_if_q + 32'd1;
      else if (wstrb_q == 4'd0)   st_ld_q <= st_ld_q + 32'd1;
      else                        st_st_q <= st_st_q + 32'd1;
    end
  end

  assign stat_ifetch = st_if_q;
  assign stat_load   = st_ld_q;
  assign stat_store  = st_st_q;
`else
  logic w_unused_instr;
  assign w_unused_instr = mem_instr;
  assign stat_ifetch    = 32'd0;
  assign stat_load      = 32'd0;
  assign stat_store     = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wait_bridge
// Description : Self-checking bench: two bridges (0 and 5 wait states), each
//               with its own SRAM, checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wait_bridge;

  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] DONE = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid   [2];
  logic        instr_s [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  wstrb_s [2];
  logic        ready_o [2];
  logic [31:0] rdata_o [2];
  logic        sen_o   [2];
  logic [3:0]  swe_o   [2];
  logic [11:0] saddr_o [2];
  logic [31:0] swd_o   [2];
  logic [31:0] srd     [2];
  logic        conv_o  [2];
  logic [7:0]  cond_o  [2];
  logic        done_o  [2];
  logic [31:0] code_o  [2];
  logic        bad_o   [2];
  logic [31:0] sif_o   [2];
  logic [31:0] sld_o   [2];
  logic [31:0] sst_o   [2];

  mem_wait_bridge #(.MEM_WORDS(4096), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_valid(valid[0]), .mem_instr(instr_s[0]),
    .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]), .mem_wstrb(wstrb_s[0]),
    .mem_ready(ready_o[0]), .mem_rdata(rdata_o[0]), .sram_en(sen_o[0]),
    .sram_we(swe_o[0]), .sram_addr(saddr_o[0]), .sram_wdata(swd_o[0]),
    .sram_rdata(srd[0]), .con_valid(conv_o[0]), .con_data(cond_o[0]),
    .done(done_o[0]), .done_code(code_o[0]), .bad_access(bad_o[0]),
    .stat_ifetch(sif_o[0]), .stat_load(sld_o[0]), .stat_store(sst_o[0]));

  mem_wait_bridge #(.MEM_WORDS(4096), .WAIT_CYCLES(5)) u_dut5 (
    .clk(clk), .rst(rst), .mem_valid(valid[1]), .mem_instr(instr_s[1]),
    .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]), .mem_wstrb(wstrb_s[1]),
    .mem_ready(ready_o[1]), .mem_rdata(rdata_o[1]), .sram_en(sen_o[1]),
    .sram_we(swe_o[1]), .sram_addr(saddr_o[1]), .sram_wdata(swd_o[1]),
    .sram_rdata(srd[1]), .con_valid(conv_o[1]), .con_data(cond_o[1]),
    .done(done_o[1]), .done_code(code_o[1]), .bad_access(bad_o[1]),
    .stat_ifetch(sif_o[1]), .stat_load(sld_o[1]), .stat_store(sst_o[1]));

  // Synchronous single-port SRAM per bridge: data one cycle after enable
  logic [31:0] sram_mem [2][4096];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sen_o[d]) begin
        for (int b = 0; b < 4; b++)
          if (swe_o[d][b]) sram_mem[d][saddr_o[d]][8*b +: 8] <= swd_o[d][8*b +: 8];
        srd[d] <= sram_mem[d][saddr_o[d]];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int waitc [2] = '{0, 5};

  // Behavioural reference state
  logic [31:0] ref_mem [2][4096];
  logic        ex_done [2] = '{1'b0, 1'b0};
  logic [31:0] ex_code [2] = '{32'd0, 32'd0};
  logic        ex_bad  [2] = '{1'b0, 1'b0};
  int          st_if   [2] = '{0, 0};
  int          st_ld   [2] = '{0, 0};
  int          st_st   [2] = '{0, 0};

  typedef struct {
    int          lat;
    logic [31:0] rd;
    int          nsr;
    logic [11:0] sa;
    logic [3:0]  swe;
    logic [31:0] swd;
    int          ncon;
    logic [7:0]  cd;
  } obs_t;

  typedef struct {
    int          d;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    int          exp_sram;
    logic [11:0] exp_sa;
    logic [3:0]  exp_swe;
    int          exp_con;
    logic [7:0]  exp_cd;
    logic        exp_bad;
    logic        exp_done;
    logic [31:0] exp_code;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain address arithmetic over the memory map
  task automatic model_apply(input int d, input logic ins, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws,
                             output logic [31:0] erd, output int ensr,
                             output int encon, output logic [7:0] ecd);
    int w;
    erd = 32'd0; ensr = 0; encon = 0; ecd = 8'd0;
    if (a < 32'd16384) begin
      ensr = 1;
      w = int'(a / 4);
      if (ws == 4'd0) erd = ref_mem[d][w];
      for (int b = 0; b < 4; b++)
        if (ws[b]) ref_mem[d][w][8*b +: 8] = wd[8*b +: 8];
    end else if ((a / 4) == (CON / 4)) begin
      if (ws[0]) begin encon = 1; ecd = wd[7:0]; end
    end else if ((a / 4) == (DONE / 4)) begin
      if (ws != 4'd0) begin ex_done[d] = 1'b1; ex_code[d] = wd; end
    end else begin
      ex_bad[d] = 1'b1;
    end
    if (ins) st_if[d]++;
    else if (ws == 4'd0) st_ld[d]++;
    else st_st[d]++;
  endtask

  // One transaction; caller is at a negedge with the bridge idle
  task automatic run_txn(input int d, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws, output obs_t o);
    o = '{lat: -1, rd: 32'd0, nsr: 0, sa: 12'd0, swe: 4'd0, swd: 32'd0, ncon: 0, cd: 8'd0};
    valid[d] = 1'b1; instr_s[d] = ins; addr_s[d] = a; wdata_s[d] = wd; wstrb_s[d] = ws;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Request must be latched: drop valid and scramble the bus
        valid[d] = 1'b0; addr_s[d] = $urandom; wdata_s[d] = $urandom;
        wstrb_s[d] = 4'($urandom); instr_s[d] = 1'($urandom);
      end
      if (!sen_o[d]) chk("we_without_en", 32'(swe_o[d]), 32'd0);
      if (sen_o[d]) begin
        o.nsr++; o.sa = saddr_o[d]; o.swe = swe_o[d]; o.swd = swd_o[d];
      end
      if (conv_o[d]) begin o.ncon++; o.cd = cond_o[d]; end
      if (ready_o[d]) begin o.lat = c; o.rd = rdata_o[d]; break; end
    end
    chk("latency", 32'(o.lat), 32'(waitc[d] + 3));
    @(negedge clk);
    chk("ready_pulse_end", 32'(ready_o[d]), 32'd0);
    chk("rdata_cleared", rdata_o[d], 32'd0);
  endtask

  task automatic check_zero(input int d);
    chk("z_ready", 32'(ready_o[d]), 0); chk("z_rdata", rdata_o[d], 0);
    chk("z_sram_en", 32'(sen_o[d]), 0); chk("z_sram_we", 32'(swe_o[d]), 0);
    chk("z_sram_addr", 32'(saddr_o[d]), 0); chk("z_sram_wdata", swd_o[d], 0);
    chk("z_con_valid", 32'(conv_o[d]), 0); chk("z_con_data", 32'(cond_o[d]), 0);
    chk("z_done", 32'(done_o[d]), 0); chk("z_done_code", code_o[d], 0);
    chk("z_bad", 32'(bad_o[d]), 0); chk("z_stat_if", sif_o[d], 0);
    chk("z_stat_ld", sld_o[d], 0); chk("z_stat_st", sst_o[d], 0);
  endtask

  // Random/preload transaction checked against the model
  task automatic do_rand(input int d, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    obs_t o; logic [31:0] erd; int ensr, encon; logic [7:0] ecd;
    run_txn(d, ins, a, wd, ws, o);
    model_apply(d, ins, a, wd, ws, erd, ensr, encon, ecd);
    chk("r_rdata", o.rd, erd);
    chk("r_sram_count", 32'(o.nsr), 32'(ensr));
    if (ensr != 0) begin
      chk("r_sram_addr", 32'(o.sa), 32'(a[13:2]));
      chk("r_sram_we", 32'(o.swe), 32'(ws));
      if (ws != 4'd0) chk("r_sram_wdata", o.swd, wd);
    end
    chk("r_con_count", 32'(o.ncon), 32'(encon));
    if (encon != 0) chk("r_con_data", 32'(o.cd), 32'(ecd));
    chk("r_bad", 32'(bad_o[d]), 32'(ex_bad[d]));
    chk("r_done", 32'(done_o[d]), 32'(ex_done[d]));
    chk("r_done_code", code_o[d], ex_code[d]);
  endtask

  // Held-high valid: second response follows the first by RESP->IDLE + full latency
  task automatic back_to_back(input int d);
    int c1 = -1, c2 = -1, nrdy = 0;
    logic [31:0] r1 = 32'd0, r2 = 32'd0, erd; int ensr, encon; logic [7:0] ecd;
    valid[d] = 1'b1; instr_s[d] = 1'b0; addr_s[d] = 32'd0; wdata_s[d] = 32'd0; wstrb_s[d] = 4'd0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ready_o[d]) begin
        if (c1 < 0) begin c1 = c; r1 = rdata_o[d]; end
        else begin c2 = c; r2 = rdata_o[d]; valid[d] = 1'b0; break; end
      end
    end
    valid[d] = 1'b0;
    model_apply(d, 1'b0, 32'd0, 32'd0, 4'd0, erd, ensr, encon, ecd);
    model_apply(d, 1'b0, 32'd0, 32'd0, 4'd0, erd, ensr, encon, ecd);
    chk("b2b_first_lat", 32'(c1), 32'(waitc[d] + 3));
    chk("b2b_gap", 32'(c2 - c1), 32'(waitc[d] + 4));
    chk("b2b_rdata1", r1, erd);
    chk("b2b_rdata2", r2, erd);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ready_o[d]) nrdy++;
    end
    chk("b2b_no_extra_ready", 32'(nrdy), 32'd0);
  endtask

  vec_t tbl [15];

  initial begin
    obs_t o; logic [31:0] erd; int ensr, encon; logic [7:0] ecd;
    int d, kind, nrdy;
    logic [31:0] a, wd; logic [3:0] ws; logic ins;

    //           d ins addr          wdata          wstrb  exp_rd        sr  sa      swe    con cd     bad   done  code
    tbl[0]  = '{0, 0, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1, 12'd4,  4'hF, 0, 8'h0,  1'b0, 1'b0, 32'h0};
    tbl[1]  = '{0, 0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1, 12'd4,  4'h0, 0, 8'h0,  1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1, 0, 32'h20,       32'hAAAABBBB, 4'hF, 32'h0,        1, 12'd8,  4'hF, 0, 8'h0,  1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1, 0, 32'h20,       32'h12345678, 4'h3, 32'h0,        1, 12'd8,  4'h3, 0, 8'h0,  1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1, 0, 32'h20,       32'h0,        4'h0, 32'hAAAA5678, 1, 12'd8,  4'h0, 0, 8'h0,  1'b0, 1'b0, 32'h0};
    tbl[5]  = '{0, 0, CON,          32'h00000041, 4'h1, 32'h0,        0, 12'd0,  4'h0, 1, 8'h41, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{0, 0, DONE,         32'h00000001, 4'hF, 32'h0,        0, 12'd0,  4'h0, 0, 8'h0,  1'b0, 1'b1, 32'h1};
    tbl[7]  = '{0, 0, DONE,         32'h0000002A, 4'h1, 32'h0,        0, 12'd0,  4'h0, 0, 8'h0,  1'b0, 1'b1, 32'h2A};
    tbl[8]  = '{0, 0, 32'h08000000, 32'h0,        4'h0, 32'h0,        0, 12'd0,  4'h0, 0, 8'h0,  1'b1, 1'b1, 32'h2A};
    tbl[9]  = '{1, 0, 32'h3FFC,     32'h0BADF00D, 4'hF, 32'h0,        1, 12'hFFF, 4'hF, 0, 8'h0, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1, 1, 32'h3FFE,     32'h0,        4'h0, 32'h0BADF00D, 1, 12'hFFF, 4'h0, 0, 8'h0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1, 0, 32'h4000,     32'h0,        4'h0, 32'h0,        0, 12'd0,  4'h0, 0, 8'h0,  1'b1, 1'b0, 32'h0};
    tbl[12] = '{0, 0, CON,          32'h0,        4'h0, 32'h0,        0, 12'd0,  4'h0, 0, 8'h0,  1'b1, 1'b1, 32'h2A};
    tbl[13] = '{0, 0, CON | 32'h2,  32'h00005555, 4'h2, 32'h0,        0, 12'd0,  4'h0, 0, 8'h0,  1'b1, 1'b1, 32'h2A};
    tbl[14] = '{0, 0, 32'h13,       32'h0,        4'h0, 32'hDEADBEEF, 1, 12'd4,  4'h0, 0, 8'h0,  1'b1, 1'b1, 32'h2A};

    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; instr_s[i] = 1'b0; addr_s[i] = 32'd0; wdata_s[i] = 32'd0; wstrb_s[i] = 4'd0;
    end

    // Power-on reset
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].d, tbl[i].instr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, o);
      model_apply(tbl[i].d, tbl[i].instr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb,
                  erd, ensr, encon, ecd);
      chk("t_rdata", o.rd, tbl[i].exp_rd);
      chk("t_sram_count", 32'(o.nsr), 32'(tbl[i].exp_sram));
      if (tbl[i].exp_sram != 0) begin
        chk("t_sram_addr", 32'(o.sa), 32'(tbl[i].exp_sa));
        chk("t_sram_we", 32'(o.swe), 32'(tbl[i].exp_swe));
      end
      chk("t_con_count", 32'(o.ncon), 32'(tbl[i].exp_con));
      if (tbl[i].exp_con != 0) chk("t_con_data", 32'(o.cd), 32'(tbl[i].exp_cd));
      chk("t_bad", 32'(bad_o[tbl[i].d]), 32'(tbl[i].exp_bad));
      chk("t_done", 32'(done_o[tbl[i].d]), 32'(tbl[i].exp_done));
      chk("t_done_code", code_o[tbl[i].d], tbl[i].exp_code);
    end

    // Preload a small window, then random mix against the model
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 32; w++)
        do_rand(i, 1'b0, 32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 80; n++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      ins  = 1'b0; wd = $urandom; ws = 4'd0;
      a    = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if (kind >= 3 && kind <= 4) ins = 1'b1;
      else if (kind >= 5 && kind <= 7) ws = 4'($urandom_range(1, 15));
      else if (kind == 8) begin a = CON; ws = 4'($urandom_range(0, 15)); end
      else if (kind == 9) a = 32'h0000_4000 + ($urandom & 32'h07FF_FFFF);
      do_rand(d, ins, a, wd, ws);
    end

    back_to_back(0);
    back_to_back(1);

`ifdef MEM_WAIT_BRIDGE_STATS_EN
    for (int i = 0; i < 2; i++) begin
      chk("stat_ifetch", sif_o[i], 32'(st_if[i]));
      chk("stat_load",   sld_o[i], 32'(st_ld[i]));
      chk("stat_store",  sst_o[i], 32'(st_st[i]));
    end
`else
    for (int i = 0; i < 2; i++) begin
      chk("stat_ifetch_off", sif_o[i], 32'd0);
      chk("stat_load_off",   sld_o[i], 32'd0);
      chk("stat_store_off",  sst_o[i], 32'd0);
    end
`endif

    // Asynchronous reset while the 5-wait bridge is in WAIT
    valid[1] = 1'b1; instr_s[1] = 1'b0; addr_s[1] = 32'd0; wstrb_s[1] = 4'd0;
    @(negedge clk);
    valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero(0);
    check_zero(1);
    nrdy = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready_o[1]) nrdy++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ready_o[1]) nrdy++;
    end
    chk("rst_no_ready", 32'(nrdy), 32'd0);
    chk("rst_done_cleared", 32'(done_o[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
